shot_clock_ctrl: RTL

Control sequencer for the two-digit BCD 24-second shot-clock counter (C_24). It sits between the debounced referee buttons and the counter. It drives the counter's load, load data and count-enable inputs, reads back the BCD digits, and generates the expiry buzzer. The counter is the responder; this block is the initiator.

---
 rtl/shot_clock_ctrl_if.sv | 32 +++
 rtl/shot_clock_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/shot_clock_ctrl_if.sv
// Counter-side bus between the shot-clock sequencer and the two-digit BCD counter.
//   D1, D0 : load data (tens, ones), driven by the sequencer
//   PE_n   : active-low parallel-load strobe, driven by the sequencer
//   CE     : count enable (one-cycle pulses), driven by the sequencer
//   Q1, Q0 : current counter digits (BCD), driven by the counter
// master = sequencer (initiator), slave = counter (responder).
interface shot_clock_ctrl_if;
    logic [3:0] D1;
    logic [3:0] D0;
    logic       PE_n;
    logic       CE;
    logic [3:0] Q1;
    logic [3:0] Q0;

    modport master (
        output D1,
        output D0,
        output PE_n,
        output CE,
        input  Q1,
        input  Q0
    );

    modport slave (
        input  D1,
        input  D0,
        input  PE_n,
        input  CE,
        output Q1,
        output Q0
    );
endinterface

// File: rtl/shot_clock_ctrl.sv
// Shot-clock control sequencer for the 24-second BCD down-counter.
// Turns the referee buttons into load / count-enable commands for the counter and
// raises the expiry buzzer when the counter reaches 00.
// Ports:
//   CP       : system clock, rising edge
//   CR       : asynchronous active-low reset
//   start    : start/resume button (asynchronous level)
//   pause    : pause button (asynchronous level)
//   reload   : reload-to-24 button (asynchronous level)
//   ctr      : counter bus (load data, PE_n, CE out; Q digits in)
//   running  : high while counting
//   expired  : high once the counter has reached 00
//   buzzer   : expiry buzzer, high for BUZZ_CYCLES cycles on expiry
module shot_clock_ctrl #(
    parameter int unsigned TICK_DIV    = 4,
    parameter int unsigned BUZZ_CYCLES = 8,
    parameter logic [3:0]  LOAD_TENS   = 4'd2,
    parameter logic [3:0]  LOAD_ONES   = 4'd4
) (
    input  logic              CP,
    input  logic              CR,
    input  logic              start,
    input  logic              pause,
    input  logic              reload,
    shot_clock_ctrl_if.master ctr,
    output logic              running,
    output logic              expired,
    output logic              buzzer
);

    localparam int unsigned DivW  = $clog2(TICK_DIV);
    localparam int unsigned BuzzW = $clog2(BUZZ_CYCLES + 1);

    typedef enum logic [2:0] {
        StInit,
        StLoad,
        StReady,
        StRun,
        StPause,
        StExpire
    } state_e;

    state_e           state_q, state_d;
    logic [DivW-1:0]  div_q, div_d;
    logic [BuzzW-1:0] buzz_q, buzz_d;
    logic             pe_n_q, pe_n_d;
    logic             ce_q, ce_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             buzzer_q, buzzer_d;

    // Button bits: [2] reload, [1] pause, [0] start.
    logic [2:0] sync1_q, sync2_q, prev_q;
    logic [2:0] ev;
    logic       ev_start, ev_pause, ev_reload;
    logic       q_zero;
    logic       div_last;

    assign ev        = sync2_q & ~prev_q;
    assign ev_start  = ev[0];
    assign ev_pause  = ev[1];
    assign ev_reload = ev[2];

    // Digits above 9 count as non-zero; only an exact 00 means expiry.
    assign q_zero   = ({ctr.Q1, ctr.Q0} == 8'h00);
    assign div_last = (div_q == DivW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        buzz_d  = buzz_q;
        ce_d    = 1'b0;

        if (state_q != StInit && ev_reload) begin
            state_d = StLoad;
            div_d   = '0;
            buzz_d  = '0;
        end else begin
            unique case (state_q)
                StInit:  state_d = StLoad;
                StLoad:  state_d = StReady;
                StReady: begin
                    if (ev_start) begin
                        state_d = StRun;
                        div_d   = '0;
                    end
                end
                StRun: begin
                    // Expiry beats pause so a zero counter always ends in EXPIRE.
                    if (q_zero) begin
                        state_d = StExpire;
                        buzz_d  = BuzzW'(BUZZ_CYCLES);
                    end else if (ev_pause) begin
                        // Divider left untouched so resume continues the same second.
                        state_d = StPause;
                    end else begin
                        ce_d  = div_last;
                        div_d = div_last ? '0 : div_q + DivW'(1);
                    end
                end
                StPause: begin
                    if (ev_start) begin
                        state_d = StRun;
                    end
                end
                StExpire: begin
                    if (buzz_q != '0) begin
                        buzz_d = buzz_q - BuzzW'(1);
                    end
                end
                default: state_d = StInit;
            endcase
        end

        pe_n_d    = (state_d != StLoad);
        running_d = (state_d == StRun);
        expired_d = (state_d == StExpire);
        buzzer_d  = (buzz_d != '0);
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_q   <= StInit;
            div_q     <= '0;
            buzz_q    <= '0;
            pe_n_q    <= 1'b1;
            ce_q      <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
            buzzer_q  <= 1'b0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            buzz_q    <= buzz_d;
            pe_n_q    <= pe_n_d;
            ce_q      <= ce_d;
            running_q <= running_d;
            expired_q <= expired_d;
            buzzer_q  <= buzzer_d;
            sync1_q   <= {reload, pause, start};
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
        end
    end

    assign ctr.D1   = LOAD_TENS;
    assign ctr.D0   = LOAD_ONES;
    assign ctr.PE_n = pe_n_q;
    assign ctr.CE   = ce_q;
    assign running  = running_q;
    assign expired  = expired_q;
    assign buzzer   = buzzer_q;

endmodule
